// File: rtl/replica_pkg.sv
// Shared types and constants for the replica node.
// Ordering-port FSM/mode enums and the node word layout.
package replica_pkg;

  localparam int city_div_log = 8;
  localparam int LANES        = 8;
  localparam int LANE_W       = 7;

  typedef logic [LANES-1:0][LANE_W-1:0] replica_data_t;

  typedef enum logic [1:0] {
    IDLE,
    GAP,
    BODY
  } ordering_state_t;

  typedef enum logic {
    WRITE,
    READ
  } ordering_mode_t;

endpackage

// File: rtl/ordering_port_if.sv
// Host DMA side of the ordering port: request, beat data and
// the read-return channel.
interface ordering_port_if #(
  parameter int LANES = replica_pkg::LANES,
  parameter int NUM_W = replica_pkg::city_div_log
);

  logic [NUM_W-1:0]   ordering_num;
  logic               ordering_write;
  logic               ordering_read;
  logic [LANES*8-1:0] ordering_wdata;
  logic               ordering_ready;
  logic               ordering_rvalid;
  logic [LANES*8-1:0] ordering_rdata;

  modport master (
    output ordering_num,
    output ordering_write,
    output ordering_read,
    output ordering_wdata,
    input  ordering_ready,
    input  ordering_rvalid,
    input  ordering_rdata
  );

  modport slave (
    input  ordering_num,
    input  ordering_write,
    input  ordering_read,
    input  ordering_wdata,
    output ordering_ready,
    output ordering_rvalid,
    output ordering_rdata
  );

endinterface

// File: rtl/valid_delay_line.sv
// Fixed-depth pipeline; only the valid bits are reset,
// payload flops load only when a valid beat moves in.
module valid_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [WIDTH-1:0] dat_q [DEPTH];
  logic [WIDTH-1:0] dat_d [DEPTH];

  always_comb begin
    vld_d = '0;
    for (int i = 0; i < DEPTH; i++) dat_d[i] = dat_q[i];
    vld_d[0] = in_valid;
    if (in_valid) dat_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i] = vld_q[i-1];
      if (vld_q[i-1]) dat_d[i] = dat_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) vld_q <= '0;
    else          vld_q <= vld_d;
  end

  always_ff @(posedge clk) begin
    dat_q <= dat_d;
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_data  = dat_q[DEPTH-1];

endmodule

// File: rtl/ordering_port.sv
// Host ordering port: framed write/read transfers, exchange-shift
// pulse per header, lane-reversing write pipe and read return.
module ordering_port
  import replica_pkg::*;
#(
  parameter int LANES   = replica_pkg::LANES,
  parameter int LANE_W  = replica_pkg::LANE_W,
  parameter int NUM_W   = replica_pkg::city_div_log,
  parameter int LATENCY = 3
) (
  input  logic                         clk,
  input  logic                         reset_n,
  ordering_port_if.slave               host,
  output logic                         exchange_shift,
  output logic                         exchange_shift_d,
  output logic                         ordering_reg_valid,
  output logic [LANES-1:0][LANE_W-1:0] ordering_reg_data,
  input  logic                         node_rvalid,
  input  logic [LANES-1:0][LANE_W-1:0] node_rdata,
  output logic                         node_rready,
  output logic                         frame_busy,
  output logic                         frame_error
);

  ordering_state_t state_q, state_d;
  ordering_mode_t  mode_q, mode_d;

  logic [NUM_W-1:0]   cnt_q, cnt_d;
  logic [NUM_W-1:0]   num_q, num_d;
  logic               err_q, err_d;
  logic               xsd_q;
  logic               rvalid_q;
  logic [LANES*8-1:0] rdata_q, rdata_d;

  logic w, r, ready, wr_acc, rd_acc;
  logic [LANES-1:0][LANE_W-1:0] wmap;
  logic [LANES*8-1:0]           rmap;
  logic [LANES*LANE_W-1:0]      pipe_out;
  logic                         pipe_vld;

  assign w = host.ordering_write;
  assign r = host.ordering_read;

  // Lane i pairs with host byte LANES-1-i in both directions.
  always_comb begin
    wmap = '0;
    rmap = '0;
    for (int i = 0; i < LANES; i++) begin
      wmap[i] = host.ordering_wdata[8*(LANES-1-i) +: LANE_W];
      rmap[8*(LANES-1-i) +: 8] = 8'(node_rdata[i]);
    end
  end

  always_comb begin
    state_d        = state_q;
    mode_d         = mode_q;
    cnt_d          = cnt_q;
    num_d          = num_q;
    err_d          = err_q;
    ready          = 1'b0;
    exchange_shift = 1'b0;
    node_rready    = 1'b0;
    wr_acc         = 1'b0;
    rd_acc         = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = !(w && r);
        if (w && r) begin
          err_d = 1'b1;
        end else if (w || r) begin
          exchange_shift = 1'b1;
          cnt_d          = NUM_W'(1);
          num_d          = host.ordering_num;
          mode_d         = r ? READ : WRITE;
          err_d          = 1'b0;
          if (host.ordering_num != '0)
            state_d = r ? BODY : GAP;
        end
      end
      GAP: state_d = BODY;
      BODY: begin
        if ((mode_q == WRITE) ? r : w) begin
          err_d   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else if (mode_q == WRITE) begin
          ready  = 1'b1;
          wr_acc = w;
        end else begin
          node_rready = r;
          ready       = r && node_rvalid;
          rd_acc      = r && node_rvalid;
        end
        if (wr_acc || rd_acc) begin
          if (cnt_q == num_q) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rdata_d = rd_acc ? rmap : rdata_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      mode_q   <= WRITE;
      cnt_q    <= '0;
      num_q    <= '0;
      err_q    <= 1'b0;
      xsd_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      num_q    <= num_d;
      err_q    <= err_d;
      xsd_q    <= exchange_shift;
      rvalid_q <= rd_acc;
      rdata_q  <= rdata_d;
    end
  end

  valid_delay_line #(
    .WIDTH (LANES*LANE_W),
    .DEPTH (LATENCY)
  ) u_pipe (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (wr_acc),
    .in_data   (wmap),
    .out_valid (pipe_vld),
    .out_data  (pipe_out)
  );

  assign ordering_reg_valid   = pipe_vld;
  assign ordering_reg_data    = pipe_vld ? pipe_out : '0;
  assign host.ordering_ready  = ready;
  assign host.ordering_rvalid = rvalid_q;
  assign host.ordering_rdata  = rdata_q;
  assign exchange_shift_d     = xsd_q;
  assign frame_busy           = (state_q != IDLE);
  assign frame_error          = err_q;

endmodule

// File: tb/tb_ordering_port.sv
// Directed bench: two ports (latency 3 and 4) share host stimulus.
module tb_ordering_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [7:0]  num = '0;
  logic [63:0] wdata = '0;
  logic        nrv = 1'b0;
  logic [7:0][6:0] nrdata = '0;

  int errors = 0;
  int checks = 0;
  int cyc_n = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  ordering_port_if h3 ();
  ordering_port_if h4 ();

  assign h3.ordering_num   = num;
  assign h3.ordering_write = wr;
  assign h3.ordering_read  = rd;
  assign h3.ordering_wdata = wdata;
  assign h4.ordering_num   = num;
  assign h4.ordering_write = wr;
  assign h4.ordering_read  = rd;
  assign h4.ordering_wdata = wdata;

  logic xs3, xsd3, rv3, nrr3, busy3, err3;
  logic xs4, xsd4, rv4, nrr4, busy4, err4;
  logic [7:0][6:0] rdat3, rdat4;

  ordering_port #(.LATENCY(3)) dut3 (
    .clk                (clk),
    .reset_n            (rst_n),
    .host               (h3),
    .exchange_shift     (xs3),
    .exchange_shift_d   (xsd3),
    .ordering_reg_valid (rv3),
    .ordering_reg_data  (rdat3),
    .node_rvalid        (nrv),
    .node_rdata         (nrdata),
    .node_rready        (nrr3),
    .frame_busy         (busy3),
    .frame_error        (err3)
  );

  ordering_port #(.LATENCY(4)) dut4 (
    .clk                (clk),
    .reset_n            (rst_n),
    .host               (h4),
    .exchange_shift     (xs4),
    .exchange_shift_d   (xsd4),
    .ordering_reg_valid (rv4),
    .ordering_reg_data  (rdat4),
    .node_rvalid        (nrv),
    .node_rdata         (nrdata),
    .node_rready        (nrr4),
    .frame_busy         (busy4),
    .frame_error        (err4)
  );

  int          v3_cyc[$];
  logic [55:0] v3_dat[$];
  int          v4_cyc[$];

  always @(negedge clk) begin
    if (rv3) begin
      v3_cyc.push_back(cyc_n);
      v3_dat.push_back(rdat3);
    end
    if (rv4) v4_cyc.push_back(cyc_n);
  end

  logic [7:0][6:0] exp_w;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy3 !== 1'b0 || err3 !== 1'b0 || xsd3 !== 1'b0) begin
      errors++;
      $display("FAIL rst_state: busy=%b err=%b xsd=%b want 0 0 0", busy3, err3, xsd3);
    end
    checks++;
    if (rv3 !== 1'b0 || h3.ordering_rvalid !== 1'b0 || rdat3 !== '0) begin
      errors++;
      $display("FAIL rst_valids: rv=%b rvalid=%b data=%h want 0 0 0", rv3, h3.ordering_rvalid, rdat3);
    end
    checks++;
    if (h3.ordering_ready !== 1'b1 || h3.ordering_rdata !== '0) begin
      errors++;
      $display("FAIL rst_ready: ready=%b rdata=%h want 1 0", h3.ordering_ready, h3.ordering_rdata);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_write_frame();
    int t1;
    v3_cyc.delete();
    v3_dat.delete();
    cyc();
    wr = 1'b1; num = 8'd3; wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    checks++;
    if (xs3 !== 1'b1 || h3.ordering_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_hdr: xs=%b ready=%b want 1 1", xs3, h3.ordering_ready);
    end
    cyc();
    wdata = 64'h0807_0605_0403_0201;
    #1;
    checks++;
    if (h3.ordering_ready !== 1'b0 || xs3 !== 1'b0 || xsd3 !== 1'b1 || busy3 !== 1'b1) begin
      errors++;
      $display("FAIL wr_gap: ready=%b xs=%b xsd=%b busy=%b want 0 0 1 1",
               h3.ordering_ready, xs3, xsd3, busy3);
    end
    cyc();
    t1 = cyc_n;
    #1;
    checks++;
    if (h3.ordering_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_body_ready: got %b want 1", h3.ordering_ready);
    end
    cyc();
    wdata = 64'h8887_8685_8483_8281;
    cyc();
    cyc();
    wr = 1'b0;
    #1;
    checks++;
    if (busy3 !== 1'b0) begin
      errors++;
      $display("FAIL wr_end_busy: got %b want 0", busy3);
    end
    repeat (5) cyc();
    checks++;
    if (v3_cyc.size() !== 3) begin
      errors++;
      $display("FAIL wr_count: got %0d valids want 3", v3_cyc.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (v3_cyc[k] !== t1 + 3 + k || v3_dat[k] !== exp_w) begin
          errors++;
          $display("FAIL wr_beat%0d: cycle=%0d data=%h want cycle=%0d data=%h",
                   k, v3_cyc[k], v3_dat[k], t1 + 3 + k, exp_w);
        end
      end
    end
  endtask

  task automatic test_header_only();
    v3_cyc.delete();
    cyc();
    wr = 1'b1; num = 8'd0; wdata = 64'h1122_3344_5566_7788;
    #1;
    checks++;
    if (xs3 !== 1'b1) begin
      errors++;
      $display("FAIL ho_xs: got %b want 1", xs3);
    end
    cyc();
    #1;
    checks++;
    if (xs3 !== 1'b1 || xsd3 !== 1'b1 || busy3 !== 1'b0) begin
      errors++;
      $display("FAIL ho_second: xs=%b xsd=%b busy=%b want 1 1 0", xs3, xsd3, busy3);
    end
    cyc();
    wr = 1'b0;
    #1;
    checks++;
    if (xsd3 !== 1'b1 || xs3 !== 1'b0) begin
      errors++;
      $display("FAIL ho_xsd: xsd=%b xs=%b want 1 0", xsd3, xs3);
    end
    repeat (5) cyc();
    checks++;
    if (v3_cyc.size() !== 0) begin
      errors++;
      $display("FAIL ho_novalid: got %0d valids want 0", v3_cyc.size());
    end
  endtask

  task automatic test_read_frame();
    cyc();
    rd = 1'b1; num = 8'd2; nrv = 1'b0;
    #1;
    checks++;
    if (xs3 !== 1'b1 || h3.ordering_ready !== 1'b1) begin
      errors++;
      $display("FAIL rd_hdr: xs=%b ready=%b want 1 1", xs3, h3.ordering_ready);
    end
    for (int k = 0; k < 4; k++) begin
      cyc();
      #1;
      checks++;
      if (h3.ordering_ready !== 1'b0 || nrr3 !== 1'b1 || busy3 !== 1'b1) begin
        errors++;
        $display("FAIL rd_stall%0d: ready=%b nrready=%b busy=%b want 0 1 1",
                 k, h3.ordering_ready, nrr3, busy3);
      end
    end
    cyc();
    nrv = 1'b1;
    nrdata = '0; nrdata[0] = 7'h55; nrdata[7] = 7'h2A;
    #1;
    checks++;
    if (h3.ordering_ready !== 1'b1) begin
      errors++;
      $display("FAIL rd_accept: ready=%b want 1", h3.ordering_ready);
    end
    cyc();
    nrdata = '0; nrdata[0] = 7'h7F;
    #1;
    checks++;
    if (h3.ordering_rvalid !== 1'b1 || h3.ordering_rdata !== 64'h5500_0000_0000_002A) begin
      errors++;
      $display("FAIL rd_beat0: rvalid=%b rdata=%h want 1 550000000000002a",
               h3.ordering_rvalid, h3.ordering_rdata);
    end
    cyc();
    rd = 1'b0; nrv = 1'b0;
    #1;
    checks++;
    if (h3.ordering_rvalid !== 1'b1 || h3.ordering_rdata !== 64'h7F00_0000_0000_0000
        || busy3 !== 1'b0) begin
      errors++;
      $display("FAIL rd_beat1: rvalid=%b rdata=%h busy=%b want 1 7f00000000000000 0",
               h3.ordering_rvalid, h3.ordering_rdata, busy3);
    end
    cyc();
    checks++;
    if (h3.ordering_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rd_done: rvalid=%b want 0", h3.ordering_rvalid);
    end
  endtask

  task automatic test_mode_error();
    int t1;
    v3_cyc.delete();
    cyc();
    wr = 1'b1; num = 8'd5; wdata = 64'h0807_0605_0403_0201;
    cyc();
    cyc();
    t1 = cyc_n;
    cyc();
    wr = 1'b0; rd = 1'b1;
    #1;
    checks++;
    if (h3.ordering_ready !== 1'b0) begin
      errors++;
      $display("FAIL me_ready: got %b want 0", h3.ordering_ready);
    end
    cyc();
    rd = 1'b0;
    #1;
    checks++;
    if (err3 !== 1'b1 || busy3 !== 1'b0) begin
      errors++;
      $display("FAIL me_flag: err=%b busy=%b want 1 0", err3, busy3);
    end
    repeat (4) cyc();
    checks++;
    if (v3_cyc.size() !== 1 || v3_cyc[0] !== t1 + 3) begin
      errors++;
      $display("FAIL me_drain: count=%0d first=%0d want 1 at %0d",
               v3_cyc.size(), (v3_cyc.size() > 0) ? v3_cyc[0] : -1, t1 + 3);
    end
    cyc();
    wr = 1'b1; num = 8'd0;
    #1;
    checks++;
    if (err3 !== 1'b1 || xs3 !== 1'b1) begin
      errors++;
      $display("FAIL me_hdr: err=%b xs=%b want 1 1", err3, xs3);
    end
    cyc();
    wr = 1'b0;
    #1;
    checks++;
    if (err3 !== 1'b0) begin
      errors++;
      $display("FAIL me_clear: err=%b want 0", err3);
    end
  endtask

  task automatic test_both_high();
    cyc();
    wr = 1'b1; rd = 1'b1; num = 8'd3;
    #1;
    checks++;
    if (h3.ordering_ready !== 1'b0 || xs3 !== 1'b0) begin
      errors++;
      $display("FAIL bh_ready: ready=%b xs=%b want 0 0", h3.ordering_ready, xs3);
    end
    cyc();
    wr = 1'b0; rd = 1'b0;
    #1;
    checks++;
    if (err3 !== 1'b1 || busy3 !== 1'b0 || xsd3 !== 1'b0) begin
      errors++;
      $display("FAIL bh_err: err=%b busy=%b xsd=%b want 1 0 0", err3, busy3, xsd3);
    end
  endtask

  task automatic test_reset_midframe();
    int t;
    v4_cyc.delete();
    cyc();
    wr = 1'b1; num = 8'd5; wdata = 64'h0807_0605_0403_0201;
    cyc();
    cyc();
    cyc();
    wr = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy4 !== 1'b0 || rv4 !== 1'b0 || xsd4 !== 1'b0 || err4 !== 1'b0) begin
      errors++;
      $display("FAIL mr_state: busy=%b rv=%b xsd=%b err=%b want 0 0 0 0",
               busy4, rv4, xsd4, err4);
    end
    checks++;
    if (rdat4 !== '0 || h4.ordering_rvalid !== 1'b0 || h4.ordering_ready !== 1'b1) begin
      errors++;
      $display("FAIL mr_outs: data=%h rvalid=%b ready=%b want 0 0 1",
               rdat4, h4.ordering_rvalid, h4.ordering_ready);
    end
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (8) cyc();
    checks++;
    if (v4_cyc.size() !== 0) begin
      errors++;
      $display("FAIL mr_discard: got %0d valids want 0", v4_cyc.size());
    end
    cyc();
    wr = 1'b1; num = 8'd1;
    cyc();
    cyc();
    t = cyc_n;
    cyc();
    wr = 1'b0;
    #1;
    checks++;
    if (busy4 !== 1'b0) begin
      errors++;
      $display("FAIL mr_newframe_busy: got %b want 0", busy4);
    end
    repeat (6) cyc();
    checks++;
    if (v4_cyc.size() !== 1 || v4_cyc[0] !== t + 4) begin
      errors++;
      $display("FAIL mr_newframe: count=%0d first=%0d want 1 at %0d",
               v4_cyc.size(), (v4_cyc.size() > 0) ? v4_cyc[0] : -1, t + 4);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) exp_w[i] = 7'(8 - i);
    test_reset();
    test_write_frame();
    test_header_only();
    test_read_frame();
    test_mode_error();
    test_both_high();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time %0t exceeded bound", $time);
    $fatal(1);
  end

endmodule
